aes: RTL and testbench

AES -- requirements
Module: aes

---
 rtl/aes_pkg.sv | 116 +++++++++++
 rtl/aes_core.sv | 221 ++++++++++++++++++++++
 rtl/aes.sv | 167 ++++++++++++++++
 tb/tb_aes.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES register wrapper (aes) and its cipher
// core (aes_core): register addresses, CONFIG/START/STATUS bit positions,
// key-length encodings, the core FSM state type and GF(2^8) helpers used
// to build the S-box and (Inv)MixColumns arithmetically instead of by table.
// ---------------------------------------------------------------------------
package aes_pkg;

    // Register map
    localparam logic [3:0] ADDR_IDLE   = 4'h0;
    localparam logic [3:0] ADDR_CONFIG = 4'h1;
    localparam logic [3:0] ADDR_KEY    = 4'h2;
    localparam logic [3:0] ADDR_BLOCK  = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_RESULT = 4'h5;
    localparam logic [3:0] ADDR_START  = 4'hF;

    // CONFIG write bits
    localparam int CFG_ENCDEC_BIT = 0;
    localparam int CFG_KEYLEN_BIT = 1;

    // START write bits
    localparam int START_INIT_BIT = 0;
    localparam int START_NEXT_BIT = 1;

    // STATUS read bits
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    // Key length encodings
    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    // Cipher core sequencing
    typedef enum logic [1:0] {
        CORE_IDLE   = 2'd0,
        CORE_EXPAND = 2'd1,
        CORE_CIPHER = 2'd2
    } core_state_e;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) begin
                r = gf_mul(r, p);
            end
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    // S-box applied to each byte of a key-schedule word
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for key-schedule step n (1..10)
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_core.sv
// ---------------------------------------------------------------------------
// aes_core
// Iterative AES-128/256 encrypt/decrypt. init expands the key one schedule
// word per cycle into a 60-word table; next runs one round per cycle using
// round keys read from that table (forward order for encrypt, reverse for
// the inverse cipher).
// Ports:
//   clk, rst_n        clock, async active-low reset (aborts any operation)
//   encdec            1 = encrypt, 0 = decrypt (sampled on next)
//   init, next        one-cycle requests: key expansion / process block
//   ready             1 once a key expansion has completed
//   key[255:0]        key, MSB aligned (128-bit keys occupy [255:128])
//   keylen            0 = 128-bit, 1 = 256-bit (sampled on init)
//   block[127:0]      input block (sampled on next)
//   result[127:0]     output block, held until the next accepted next
//   result_valid      1 while result holds a completed block
// ---------------------------------------------------------------------------
module aes_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         encdec,
    input  logic         init,
    input  logic         next,
    output logic         ready,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [127:0] result,
    output logic         result_valid
);

    core_state_e  state_r;
    logic [31:0]  w_r [0:59];
    logic [5:0]   widx_r;
    logic [3:0]   round_r;
    logic         keylen_r;
    logic         enc_r;
    logic [127:0] st_r;
    logic [127:0] result_r;
    logic         ready_r;
    logic         result_valid_r;

    logic [3:0]   nr_s;
    logic [5:0]   nk_s;
    logic [5:0]   wlast_s;
    logic [3:0]   rk_sel_s;
    logic [5:0]   rk_base_s;
    logic [127:0] rk_s;
    logic         last_s;
    logic [127:0] round_tmp_s;
    logic [127:0] round_out_s;
    logic [31:0]  prev_word_s;
    logic [31:0]  old_word_s;
    logic [31:0]  temp_word_s;
    logic [31:0]  new_word_s;
    logic [3:0]   rcon_idx_s;

    // SubBytes / InvSubBytes over the whole state
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   x;
        o = 128'h0;
        for (int n = 0; n < 16; n++) begin
            x = s[8*(15-n) +: 8];
            o[8*(15-n) +: 8] = inv ? inv_sbox(x) : sbox(x);
        end
        return o;
    endfunction

    // ShiftRows / InvShiftRows; byte n sits at row n%4, column n/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int           src;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (4*((c + 4 - r) % 4) + r) : (4*((c + r) % 4) + r);
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-src) +: 8];
            end
        end
        return o;
    endfunction

    // MixColumns / InvMixColumns as a circulant matrix over each column
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [31:0]  coefs;
        logic [7:0]   a [0:3];
        logic [7:0]   b;
        logic [7:0]   cf;
        o = 128'h0;
        coefs = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = s[8*(15-(4*c+k)) +: 8];
            end
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    cf = coefs[8*(3-((k - r + 4) % 4)) +: 8];
                    b = b ^ gf_mul(cf, a[k]);
                end
                o[8*(15-(4*c+r)) +: 8] = b;
            end
        end
        return o;
    endfunction

    assign nr_s    = (keylen_r == KEYLEN_256) ? 4'd14 : 4'd10;
    assign nk_s    = (keylen_r == KEYLEN_256) ? 6'd8  : 6'd4;
    assign wlast_s = (keylen_r == KEYLEN_256) ? 6'd59 : 6'd43;

    // Round key select: the first AddRoundKey key is chosen when next arrives
    always_comb begin
        if (state_r == CORE_CIPHER) begin
            rk_sel_s = round_r;
        end else begin
            rk_sel_s = encdec ? 4'd0 : nr_s;
        end
        rk_base_s = {rk_sel_s, 2'b00};
        rk_s = {w_r[rk_base_s], w_r[rk_base_s + 6'd1],
                w_r[rk_base_s + 6'd2], w_r[rk_base_s + 6'd3]};
    end

    // One cipher round; the final round skips (Inv)MixColumns
    always_comb begin
        last_s = enc_r ? (round_r == nr_s) : (round_r == 4'd0);
        if (enc_r) begin
            round_tmp_s = shift_rows(sub_bytes(st_r, 1'b0), 1'b0);
            round_out_s = (last_s ? round_tmp_s : mix_columns(round_tmp_s, 1'b0)) ^ rk_s;
        end else begin
            round_tmp_s = sub_bytes(shift_rows(st_r, 1'b1), 1'b1) ^ rk_s;
            round_out_s = last_s ? round_tmp_s : mix_columns(round_tmp_s, 1'b1);
        end
    end

    // Next key-schedule word w[widx] from w[widx-1] and w[widx-Nk]
    always_comb begin
        prev_word_s = w_r[widx_r - 6'd1];
        old_word_s  = w_r[widx_r - nk_s];
        rcon_idx_s  = (keylen_r == KEYLEN_256) ? {1'b0, widx_r[5:3]} : widx_r[5:2];
        if (((keylen_r == KEYLEN_256) && (widx_r[2:0] == 3'd0)) ||
            ((keylen_r == KEYLEN_128) && (widx_r[1:0] == 2'd0))) begin
            temp_word_s = sub_word({prev_word_s[23:0], prev_word_s[31:24]})
                          ^ {rcon(rcon_idx_s), 24'h000000};
        end else if ((keylen_r == KEYLEN_256) && (widx_r[2:0] == 3'd4)) begin
            temp_word_s = sub_word(prev_word_s);
        end else begin
            temp_word_s = prev_word_s;
        end
        new_word_s = old_word_s ^ temp_word_s;
    end

    // Core sequencer: idle / key expansion / block rounds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= CORE_IDLE;
            widx_r         <= 6'd8;
            round_r        <= 4'd0;
            keylen_r       <= KEYLEN_128;
            enc_r          <= 1'b0;
            st_r           <= 128'h0;
            result_r       <= 128'h0;
            ready_r        <= 1'b0;
            result_valid_r <= 1'b0;
            for (int j = 0; j < 60; j++) begin
                w_r[j] <= 32'h0;
            end
        end else begin
            case (state_r)
                CORE_IDLE: begin
                    if (init) begin
                        // Words beyond Nk get overwritten during expansion
                        for (int j = 0; j < 8; j++) begin
                            w_r[j] <= key[255-32*j -: 32];
                        end
                        keylen_r <= keylen;
                        widx_r   <= (keylen == KEYLEN_256) ? 6'd8 : 6'd4;
                        ready_r  <= 1'b0;
                        state_r  <= CORE_EXPAND;
                    end else if (next && ready_r) begin
                        enc_r          <= encdec;
                        st_r           <= block ^ rk_s;
                        round_r        <= encdec ? 4'd1 : (nr_s - 4'd1);
                        result_valid_r <= 1'b0;
                        state_r        <= CORE_CIPHER;
                    end
                end
                CORE_EXPAND: begin
                    w_r[widx_r] <= new_word_s;
                    if (widx_r == wlast_s) begin
                        ready_r <= 1'b1;
                        state_r <= CORE_IDLE;
                    end else begin
                        widx_r <= widx_r + 6'd1;
                    end
                end
                CORE_CIPHER: begin
                    if (last_s) begin
                        result_r       <= round_out_s;
                        result_valid_r <= 1'b1;
                        state_r        <= CORE_IDLE;
                    end else begin
                        st_r    <= round_out_s;
                        round_r <= enc_r ? (round_r + 4'd1) : (round_r - 4'd1);
                    end
                end
                default: begin
                    state_r <= CORE_IDLE;
                end
            endcase
        end
    end

    assign ready        = ready_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: rtl/aes.sv
// ---------------------------------------------------------------------------
// aes
// Register/serial wrapper around aes_core. A 4-bit address selects a
// register each cycle; key and block are loaded 16 bits at a time by
// left-shifting, the result is read a byte at a time through an
// auto-incrementing byte index.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   address[3:0]      register select (see aes_pkg), 0x0/unlisted = idle
//   data_in[15:0]     write data for CONFIG/KEY/BLOCK/START
//   data_out[7:0]     STATUS or RESULT byte, 8'h00 otherwise
// ---------------------------------------------------------------------------
module aes
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic [15:0] data_in,
    output logic [7:0]  data_out
);

    logic [255:0] key_r;
    logic [127:0] block_r;
    logic         encdec_r;
    logic         keylen_r;
    logic [3:0]   rd_idx_r;
    logic         init_r;
    logic         next_r;
    logic         wait_key_r;
    logic         wait_res_r;

    logic         core_ready_s;
    logic         core_valid_s;
    logic [127:0] core_result_s;
    logic [255:0] core_key_s;

    logic         busy_s;
    logic         cfg_we_s;
    logic         key_we_s;
    logic         blk_we_s;
    logic         init_go_s;
    logic         next_go_s;
    logic         rd_result_s;
    logic [7:0]   status_s;

    // Busy covers the pulse cycle itself plus the wait for the core to
    // report completion; wait_* may linger one cycle after completion but
    // are masked by the completion flags so they never extend busy.
    assign busy_s = init_r | next_r | (wait_key_r & ~core_ready_s)
                  | (wait_res_r & ~core_valid_s);

    // Address decode into write strobes; writes are gated while busy
    always_comb begin
        cfg_we_s    = 1'b0;
        key_we_s    = 1'b0;
        blk_we_s    = 1'b0;
        init_go_s   = 1'b0;
        next_go_s   = 1'b0;
        rd_result_s = 1'b0;
        case (address)
            ADDR_CONFIG: cfg_we_s = ~busy_s;
            ADDR_KEY:    key_we_s = ~busy_s;
            ADDR_BLOCK:  blk_we_s = ~busy_s;
            ADDR_RESULT: rd_result_s = 1'b1;
            ADDR_START: begin
                // init wins over next; next without a ready key is dropped
                init_go_s = ~busy_s & data_in[START_INIT_BIT];
                next_go_s = ~busy_s & ~data_in[START_INIT_BIT]
                          & data_in[START_NEXT_BIT] & core_ready_s;
            end
            default: begin
                cfg_we_s = 1'b0;
            end
        endcase
    end

    // Configuration, key and block shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encdec_r <= 1'b0;
            keylen_r <= KEYLEN_128;
            key_r    <= 256'h0;
            block_r  <= 128'h0;
        end else begin
            if (cfg_we_s) begin
                encdec_r <= data_in[CFG_ENCDEC_BIT];
                keylen_r <= data_in[CFG_KEYLEN_BIT];
            end
            if (key_we_s) begin
                key_r <= {key_r[239:0], data_in};
            end
            if (blk_we_s) begin
                block_r <= {block_r[111:0], data_in};
            end
        end
    end

    // Start pulses to the core and tracking of the operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_r     <= 1'b0;
            next_r     <= 1'b0;
            wait_key_r <= 1'b0;
            wait_res_r <= 1'b0;
        end else begin
            init_r <= init_go_s;
            next_r <= next_go_s;
            // The completion flag is stale while the pulse is still in flight
            if (init_go_s) begin
                wait_key_r <= 1'b1;
            end else if (core_ready_s && !init_r) begin
                wait_key_r <= 1'b0;
            end
            if (next_go_s) begin
                wait_res_r <= 1'b1;
            end else if (core_valid_s && !next_r) begin
                wait_res_r <= 1'b0;
            end
        end
    end

    // Result byte index: advances on every RESULT cycle, restarts per block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_r <= 4'd0;
        end else if (next_go_s) begin
            rd_idx_r <= 4'd0;
        end else if (rd_result_s) begin
            rd_idx_r <= rd_idx_r + 4'd1;
        end
    end

    assign core_key_s = (keylen_r == KEYLEN_256) ? key_r : {key_r[127:0], 128'h0};

    // STATUS word assembly
    always_comb begin
        status_s = 8'h00;
        status_s[STATUS_READY_BIT] = core_ready_s;
        status_s[STATUS_VALID_BIT] = core_valid_s;
    end

    // Read mux; byte 0 of the result is bits [127:120]
    always_comb begin
        case (address)
            ADDR_STATUS: data_out = status_s;
            ADDR_RESULT: data_out = core_result_s[{~rd_idx_r, 3'b000} +: 8];
            ADDR_IDLE:   data_out = 8'h00;
            default:     data_out = 8'h00;
        endcase
    end

    aes_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .encdec       (encdec_r),
        .init         (init_r),
        .next         (next_r),
        .ready        (core_ready_s),
        .key          (core_key_s),
        .keylen       (keylen_r),
        .block        (block_r),
        .result       (core_result_s),
        .result_valid (core_valid_s)
    );

endmodule

// File: tb/tb_aes.sv
// ---------------------------------------------------------------------------
// tb_aes
// Self-checking bench for aes: table of FIPS-197 vectors driven through the
// register interface, plus directed sequences for reset, ignored next,
// readout wrap, init-only start, busy-time key writes and reset mid-cipher.
// ---------------------------------------------------------------------------
module tb_aes;
    import aes_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [7:0]  data_out;

    int checks;
    int errors;

    typedef struct packed {
        logic         keylen;
        logic         enc;
        logic [255:0] key;
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [0:3];

    aes dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
        address = ADDR_IDLE;
        data_in = 16'h0000;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        data_in = 16'h0000;
        #2;
        v = data_out;
        @(posedge clk);
        #1;
        address = ADDR_IDLE;
    endtask

    task automatic poll(input int bitn, input string name);
        logic [7:0] v;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            rd(ADDR_STATUS, v);
            if (v[bitn]) found = 1'b1;
        end
        check(name, {127'h0, found}, 128'h1);
    endtask

    task automatic read16(output logic [127:0] res);
        logic [7:0] b;
        res = 128'h0;
        for (int i = 0; i < 16; i++) begin
            rd(ADDR_RESULT, b);
            res = {res[119:0], b};
        end
    endtask

    task automatic load_key(input vec_t v);
        int nw;
        wr(ADDR_CONFIG, {14'h0, v.keylen, v.enc});
        nw = v.keylen ? 16 : 8;
        for (int i = 0; i < nw; i++) begin
            wr(ADDR_KEY, v.key[255-16*i -: 16]);
        end
    endtask

    task automatic load_block(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            wr(ADDR_BLOCK, v.blk[127-16*i -: 16]);
        end
    endtask

    task automatic do_init();
        wr(ADDR_START, 16'h0001);
        idle(1);
        poll(STATUS_READY_BIT, "ready_poll");
    endtask

    task automatic do_next(output logic [127:0] res);
        wr(ADDR_START, 16'h0002);
        idle(1);
        poll(STATUS_VALID_BIT, "valid_poll");
        read16(res);
    endtask

    task automatic run_vector(input vec_t v, output logic [127:0] res);
        load_key(v);
        do_init();
        load_block(v);
        do_next(res);
    endtask

    initial begin
        logic [127:0] res;
        logic [7:0]   b;

        checks  = 0;
        errors  = 0;
        address = ADDR_IDLE;
        data_in = 16'h0000;
        rst_n   = 1'b0;

        vecs[0] = '{keylen: 1'b0, enc: 1'b1,
                    key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    blk: 128'h00112233445566778899aabbccddeeff,
                    exp: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{keylen: 1'b0, enc: 1'b0,
                    key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    blk: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    exp: 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{keylen: 1'b1, enc: 1'b1,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    blk: 128'h00112233445566778899aabbccddeeff,
                    exp: 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{keylen: 1'b1, enc: 1'b0,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    blk: 128'h8ea2b7ca516745bfeafc49904b496089,
                    exp: 128'h00112233445566778899aabbccddeeff};

        // Reset state
        idle(2);
        address = ADDR_STATUS;
        #2;
        check("status_in_reset", {120'h0, data_out}, 128'h0);
        rst_n = 1'b1;
        address = ADDR_IDLE;
        idle(1);
        rd(ADDR_STATUS, b);
        check("status_after_reset", {120'h0, b}, 128'h0);
        rd(ADDR_RESULT, b);
        check("result_after_reset", {120'h0, b}, 128'h0);

        // next with no expanded key is dropped
        load_block(vecs[0]);
        wr(ADDR_START, 16'h0002);
        idle(1);
        rd(ADDR_STATUS, b);
        check("next_not_ready_1", {120'h0, b}, 128'h0);
        idle(20);
        rd(ADDR_STATUS, b);
        check("next_not_ready_2", {120'h0, b}, 128'h0);

        // Known-answer vectors
        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i], res);
            check($sformatf("vector_%0d", i), res, vecs[i].exp);
        end

        // Readout wrap: 17th read returns byte 0 again
        run_vector(vecs[0], res);
        check("wrap_block", res, vecs[0].exp);
        rd(ADDR_RESULT, b);
        check("wrap_17th", {120'h0, b}, 128'h69);
        for (int i = 0; i < 15; i++) begin
            rd(ADDR_RESULT, b);
        end

        // Idle and unlisted addresses read zero while a result is held
        rd(ADDR_IDLE, b);
        check("idle_addr_read", {120'h0, b}, 128'h0);
        rd(4'h7, b);
        check("unlisted_addr_read", {120'h0, b}, 128'h0);

        // START 0x3: init only; result_valid and result untouched
        wr(ADDR_START, 16'h0003);
        idle(1);
        rd(ADDR_STATUS, b);
        check("start3_status_busy", {120'h0, b}, 128'h02);
        poll(STATUS_READY_BIT, "start3_ready_poll");
        rd(ADDR_STATUS, b);
        check("start3_status_done", {120'h0, b}, 128'h03);
        read16(res);
        check("start3_result_held", res, vecs[0].exp);

        // KEY writes during key expansion are ignored
        wr(ADDR_START, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            wr(ADDR_KEY, 16'hdead);
        end
        poll(STATUS_READY_BIT, "busy_ready_poll");
        do_init();
        do_next(res);
        check("busy_key_unchanged", res, vecs[0].exp);

        // Reset in the middle of an encryption
        wr(ADDR_START, 16'h0002);
        idle(3);
        rst_n = 1'b0;
        address = ADDR_STATUS;
        #2;
        check("status_mid_reset", {120'h0, data_out}, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        address = ADDR_IDLE;
        idle(2);
        rd(ADDR_STATUS, b);
        check("status_post_abort", {120'h0, b}, 128'h0);
        run_vector(vecs[0], res);
        check("rerun_after_reset", res, vecs[0].exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
